// File: rtl/mdu_if.sv
// Bus between the execute stage and the multiply/divide unit.
//   A, B     operands (rs, rt); dividend/divisor for divides
//   MDUOp    000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   Start    qualifies MDUOp/A/B for one cycle
//   Busy     operation in flight
//   HI, LO   result registers
// master: pipeline side, slave: mdu side.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MDUOp;
  logic             Start;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output A, B, MDUOp, Start,
    input  Busy, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, Start,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed at the Start edge into a pending register and written to
// HI/LO only after a per-operation latency, so the pipeline stalls on Busy.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears Busy, HI, LO, counter and pending result
//   bus    mdu_if slave: A, B, MDUOp, Start in; Busy, HI, LO out (all registered)
// Configuration macro: MDU_DIV_EN. When undefined the divider is omitted and
// DIV/DIVU are no-ops (DIV_CYCLES then only sizes the counter).
module mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [0:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Sign/zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are exact.
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;

  assign a_sx   = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
  assign b_sx   = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

`ifdef MDU_DIV_EN
  localparam logic [2:0] OpDiv  = 3'b010;
  localparam logic [2:0] OpDivu = 3'b011;

  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, uq, ur, sq, sr;
  logic [2*WIDTH-1:0] div_s, div_u;

  // Signed divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend. MIN / -1 wraps to MIN with remainder 0 here.
  always_comb begin
    a_neg = bus.A[WIDTH-1];
    b_neg = bus.B[WIDTH-1];
    a_abs = a_neg ? ('0 - bus.A) : bus.A;
    b_abs = b_neg ? ('0 - bus.B) : bus.B;
    uq    = '0;
    ur    = '0;
    if (b_abs != '0) begin
      uq = a_abs / b_abs;
      ur = a_abs % b_abs;
    end
    sq = (a_neg ^ b_neg) ? ('0 - uq) : uq;
    sr = a_neg ? ('0 - ur) : ur;
    if (bus.B == '0) begin
      div_s = {bus.A, {WIDTH{1'b1}}};
      div_u = {bus.A, {WIDTH{1'b1}}};
    end else begin
      div_s = {sr, sq};
      div_u = {bus.A % bus.B, bus.A / bus.B};
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == StIdle) begin
      if (bus.Start) begin
        case (bus.MDUOp)
          OpMult: begin
            pend_d  = prod_s;
            cnt_d   = MultCnt;
            state_d = StRun;
          end
          OpMultu: begin
            pend_d  = prod_u;
            cnt_d   = MultCnt;
            state_d = StRun;
          end
`ifdef MDU_DIV_EN
          OpDiv: begin
            pend_d  = div_s;
            cnt_d   = DivCnt;
            state_d = StRun;
          end
          OpDivu: begin
            pend_d  = div_u;
            cnt_d   = DivCnt;
            state_d = StRun;
          end
`endif
          OpMthi:  hi_d = bus.A;
          OpMtlo:  lo_d = bus.A;
          default: ;
        endcase
      end
    end else begin
      // Start is ignored in RUN, including on the completion edge.
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        hi_d    = pend_q[2*WIDTH-1:WIDTH];
        lo_d    = pend_q[WIDTH-1:0];
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Expectations track whether MDU_DIV_EN is defined for the build.
module tb_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(
    .WIDTH      (W),
    .MULT_CYCLES(NM),
    .DIV_CYCLES (ND)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: new {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = cur;
    case (op)
      MULT:  r = 64'(sa * sb);
      MULTU: r = {32'b0, a} * {32'b0, b};
      DIV:   if (DivEn) r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      DIVU:  if (DivEn) r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MTHI:  r[63:32] = a;
      MTLO:  r[31:0] = a;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op == MULT || op == MULTU) return NM;
    if ((op == DIV || op == DIVU) && DivEn) return ND;
    return 0;
  endfunction

  // Present one Start pulse; accepted (if idle) at the posedge inside this task.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Count negedges with Busy high; bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (bus.Busy === 1'b1 && cycles < 60) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", bus.HI); end
    n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", bus.LO); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int cyc;
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    bus.A = $urandom; bus.B = $urandom;  // operands must already be captured
    wait_idle(cyc);
    n_cmp++; if (cyc != NM) begin n_err++; $display("FAIL mult_cycles got %0d want %0d", cyc, NM); end
    n_cmp++; if (bus.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", bus.HI); end
    n_cmp++; if (bus.LO !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo got %h want fffffffa", bus.LO); end
    issue(MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cyc);
    n_cmp++; if (cyc != NM) begin n_err++; $display("FAIL multu_cycles got %0d want %0d", cyc, NM); end
    n_cmp++; if (bus.HI !== 32'h2) begin n_err++; $display("FAIL multu_hi got %h want 00000002", bus.HI); end
    n_cmp++; if (bus.LO !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo got %h want fffffffa", bus.LO); end
  endtask

  task automatic test_div;
    logic [2:0]  ops[4];
    logic [31:0] as[4], bs[4], ehi[4], elo[4];
    int cyc, ecyc;
    ops = '{DIV, DIVU, DIV, DIV};
    as  = '{32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h8000_0000};
    bs  = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    ehi = '{32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'h0};
    elo = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    issue(MTHI, 32'hA5A5_A5A5, 32'd0);
    issue(MTLO, 32'h5A5A_5A5A, 32'd0);
    ecyc = DivEn ? ND : 0;
    for (int i = 0; i < 4; i++) begin
      if (!DivEn) begin
        ehi[i] = 32'hA5A5_A5A5;
        elo[i] = 32'h5A5A_5A5A;
      end
      issue(ops[i], as[i], bs[i]);
      wait_idle(cyc);
      n_cmp++; if (cyc != ecyc) begin n_err++; $display("FAIL div%0d_cycles got %0d want %0d", i, cyc, ecyc); end
      n_cmp++; if (bus.HI !== ehi[i]) begin n_err++; $display("FAIL div%0d_hi got %h want %h", i, bus.HI, ehi[i]); end
      n_cmp++; if (bus.LO !== elo[i]) begin n_err++; $display("FAIL div%0d_lo got %h want %h", i, bus.LO, elo[i]); end
    end
  endtask

  task automatic test_mthi_mtlo;
    issue(MTHI, 32'h55, 32'd0);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", bus.Busy); end
    @(negedge clk);
    n_cmp++; if (bus.HI !== 32'h55) begin n_err++; $display("FAIL mthi_hi got %h want 00000055", bus.HI); end
    issue(MTLO, 32'h1357_9BDF, 32'd0);
    @(negedge clk);
    n_cmp++; if (bus.LO !== 32'h1357_9BDF) begin n_err++; $display("FAIL mtlo_lo got %h want 13579bdf", bus.LO); end
    n_cmp++; if (bus.HI !== 32'h55) begin n_err++; $display("FAIL mtlo_hi got %h want 00000055", bus.HI); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] lo_before;
    lo_before = 32'h1357_9BDF;
    issue(MULT, 32'h1234, 32'h10);            // edge k
    @(negedge clk);
    bus.MDUOp = MTLO; bus.A = 32'hDEAD_BEEF; bus.Start = 1'b1;
    @(posedge clk);                           // edge k+1, busy
    #1 bus.Start = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL ign_busy got %b want 1", bus.Busy); end
    n_cmp++; if (bus.LO !== lo_before) begin n_err++; $display("FAIL ign_lo_hold got %h want %h", bus.LO, lo_before); end
    repeat (3) @(posedge clk);                // edge k+4
    @(negedge clk);
    bus.MDUOp = MTLO; bus.A = 32'hDEAD_BEEF; bus.Start = 1'b1;
    @(posedge clk);                           // edge k+5: completion
    #1 bus.Start = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL ign_done_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.LO !== 32'h12340) begin n_err++; $display("FAIL ign_lo got %h want 00012340", bus.LO); end
    n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL ign_hi got %h want 0", bus.HI); end
    issue(MTLO, 32'hDEAD_BEEF, 32'd0);        // edge k+6: first accepted
    n_cmp++; if (bus.LO !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL next_lo got %h want deadbeef", bus.LO); end
  endtask

  task automatic test_reset_mid_run;
    issue(MTHI, 32'h1111_2222, 32'd0);
    issue(MTLO, 32'h3333_4444, 32'd0);
    issue(DivEn ? DIV : MULT, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL rst_run_hi got %h want 0", bus.HI); end
    n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL rst_run_lo got %h want 0", bus.LO); end
    @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    n_cmp++; if (bus.Busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      n_err++;
      $display("FAIL rst_late_wb got busy=%b hi=%h lo=%h want 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
    // Start presented in the same cycle reset drops is taken at the next edge.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.MDUOp = MTHI; bus.A = 32'h0000_0ACE; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    n_cmp++; if (bus.HI !== 32'h0000_0ACE) begin n_err++; $display("FAIL rst_first_start got %h want 00000ace", bus.HI); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [63:0] m;
    logic [2:0]  op;
    logic [31:0] a, b;
    int cyc;
    issue(MTHI, 32'hCAFE_0001, 32'd0);
    issue(MTLO, 32'hCAFE_0002, 32'd0);
    m = {32'hCAFE_0001, 32'hCAFE_0002};
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b);
      bus.A = $urandom; bus.B = $urandom;
      m = ref_result(op, a, b, m);
      wait_idle(cyc);
      n_cmp++; if (cyc != ref_cycles(op)) begin
        n_err++; $display("FAIL rnd%0d_cycles op=%0d got %0d want %0d", i, op, cyc, ref_cycles(op));
      end
      n_cmp++; if (bus.HI !== m[63:32]) begin
        n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, bus.HI, m[63:32]);
      end
      n_cmp++; if (bus.LO !== m[31:0]) begin
        n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, bus.LO, m[31:0]);
      end
    end
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.MDUOp = 3'b111; bus.Start = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
